// File: rtl/depth_test.sv
// Z-buffer depth test stage: accepts one fragment, reads/compares/optionally writes
// the stored depth, and forwards passing fragments downstream.
package depth_test_pkg;
  typedef logic signed [31:0] fp32_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    fp32_t       z;
    fp32_t       u;
    fp32_t       v;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        valid;
  } fragment_t;
endpackage

// state   | meaning
// IDLE    | ready for a fragment; drops off-screen / NEVER fragments in place
// RD_REQ  | requesting stored depth, address held until grant
// RD_WAIT | waiting for read data
// CMP     | compare quantised z against stored depth
// WR      | writing new depth, held until grant
// OUT     | presenting fragment downstream until accepted
module depth_test
  import depth_test_pkg::*;
#(
  parameter int FB_WIDTH    = 640,
  parameter int FB_HEIGHT   = 480,
  parameter int DEPTH_BITS  = 16,
  parameter int Z_FRAC_BITS = 16,
  parameter int ADDR_BITS   = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  test_en,
  input  logic                  write_en,
  input  logic [2:0]            depth_func,
  input  fragment_t             frag_in,
  input  logic                  frag_in_valid,
  output logic                  frag_in_ready,
  output fragment_t             frag_out,
  output logic                  frag_out_valid,
  input  logic                  frag_out_ready,
  output logic                  zb_rd_req,
  output logic [ADDR_BITS-1:0]  zb_rd_addr,
  input  logic                  zb_rd_gnt,
  input  logic                  zb_rd_valid,
  input  logic [DEPTH_BITS-1:0] zb_rd_data,
  output logic                  zb_wr_req,
  output logic [ADDR_BITS-1:0]  zb_wr_addr,
  output logic [DEPTH_BITS-1:0] zb_wr_data,
  input  logic                  zb_wr_gnt,
  output logic                  busy,
  output logic [31:0]           pass_count,
  output logic [31:0]           fail_count
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, CMP, WR, OUT} state_t;

  localparam logic [2:0] F_NEVER    = 3'd0;
  localparam logic [2:0] F_LESS     = 3'd1;
  localparam logic [2:0] F_EQUAL    = 3'd2;
  localparam logic [2:0] F_LEQUAL   = 3'd3;
  localparam logic [2:0] F_GREATER  = 3'd4;
  localparam logic [2:0] F_NOTEQUAL = 3'd5;
  localparam logic [2:0] F_GEQUAL   = 3'd6;
  localparam logic [2:0] F_ALWAYS   = 3'd7;

  state_t                state, state_nxt;
  fragment_t             frag_q;
  logic [ADDR_BITS-1:0]  addr_q, addr_calc;
  logic [DEPTH_BITS-1:0] qz_q, qz_calc, stored_q;
  logic                  we_q;
  logic [2:0]            func_q;
  logic                  accept, off_screen, depth_pass, pass_inc, fail_inc;

  assign accept     = frag_in_valid && (state == IDLE);
  assign off_screen = (32'(frag_in.x) >= FB_WIDTH) || (32'(frag_in.y) >= FB_HEIGHT);
  assign addr_calc  = ADDR_BITS'(frag_in.y) * ADDR_BITS'(FB_WIDTH) + ADDR_BITS'(frag_in.x);

  // Signed fixed-point z clamped into [0, 1) before taking the top fraction bits
  always_comb begin
    qz_calc = frag_in.z[Z_FRAC_BITS-1 -: DEPTH_BITS];
    if ($signed(frag_in.z) < 0)
      qz_calc = '0;
    else if ($signed(frag_in.z) >= $signed(32'(1 << Z_FRAC_BITS)))
      qz_calc = '1;
  end

  always_comb begin
    case (func_q)
      F_NEVER:    depth_pass = 1'b0;
      F_LESS:     depth_pass = qz_q <  stored_q;
      F_EQUAL:    depth_pass = qz_q == stored_q;
      F_LEQUAL:   depth_pass = qz_q <= stored_q;
      F_GREATER:  depth_pass = qz_q >  stored_q;
      F_NOTEQUAL: depth_pass = qz_q != stored_q;
      F_GEQUAL:   depth_pass = qz_q >= stored_q;
      default:    depth_pass = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt      = state;
    pass_inc       = 1'b0;
    fail_inc       = 1'b0;
    frag_in_ready  = (state == IDLE);
    zb_rd_req      = (state == RD_REQ);
    zb_wr_req      = (state == WR);
    frag_out_valid = (state == OUT);
    busy           = (state != IDLE);
    case (state)
      IDLE: begin
        if (frag_in_valid) begin
          if (off_screen)                 fail_inc  = 1'b1;
          else if (!test_en)              state_nxt = OUT;
          else if (depth_func == F_NEVER) fail_inc  = 1'b1;
          else if (depth_func == F_ALWAYS) state_nxt = write_en ? WR : OUT;
          else                            state_nxt = RD_REQ;
        end
      end
      RD_REQ:  if (zb_rd_gnt) state_nxt = RD_WAIT;
      RD_WAIT: if (zb_rd_valid) state_nxt = CMP;
      CMP: begin
        if (!depth_pass) begin
          fail_inc  = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = we_q ? WR : OUT;
        end
      end
      WR: if (zb_wr_gnt) state_nxt = OUT;
      OUT: begin
        if (frag_out_ready) begin
          pass_inc  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    frag_out       = frag_q;
    frag_out.valid = frag_out_valid;
  end

  assign zb_rd_addr = addr_q;
  assign zb_wr_addr = addr_q;
  assign zb_wr_data = qz_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      frag_q     <= '0;
      addr_q     <= '0;
      qz_q       <= '0;
      stored_q   <= '0;
      we_q       <= 1'b0;
      func_q     <= F_NEVER;
      pass_count <= '0;
      fail_count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        frag_q <= frag_in;
        addr_q <= addr_calc;
        qz_q   <= qz_calc;
        we_q   <= write_en;
        func_q <= depth_func;
      end
      if (state == RD_WAIT && zb_rd_valid) stored_q <= zb_rd_data;
      if (pass_inc && pass_count != '1) pass_count <= pass_count + 32'd1;
      if (fail_inc && fail_count != '1) fail_count <= fail_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_depth_test.sv
// Directed bench for depth_test: handshake sequencing, depth compare outcomes,
// drops, stalls and mid-transaction reset.
module tb_depth_test;
  import depth_test_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        test_en, write_en;
  logic [2:0]  depth_func;
  fragment_t   frag_in, frag_out;
  logic        frag_in_valid, frag_in_ready, frag_out_valid, frag_out_ready;
  logic        zb_rd_req, zb_rd_gnt, zb_rd_valid, zb_wr_req, zb_wr_gnt, busy;
  logic [18:0] zb_rd_addr, zb_wr_addr;
  logic [15:0] zb_rd_data, zb_wr_data;
  logic [31:0] pass_count, fail_count;

  int checks = 0;
  int errors = 0;
  int rd_cycles = 0, rd_hs = 0, wr_cycles = 0, wr_hs = 0, out_hs = 0;
  int rd0, rdh0, wr0, wrh0, out0;
  fragment_t f;

  always #5 clk = ~clk;

  depth_test dut (
    .clk(clk), .rst(rst), .test_en(test_en), .write_en(write_en), .depth_func(depth_func),
    .frag_in(frag_in), .frag_in_valid(frag_in_valid), .frag_in_ready(frag_in_ready),
    .frag_out(frag_out), .frag_out_valid(frag_out_valid), .frag_out_ready(frag_out_ready),
    .zb_rd_req(zb_rd_req), .zb_rd_addr(zb_rd_addr), .zb_rd_gnt(zb_rd_gnt),
    .zb_rd_valid(zb_rd_valid), .zb_rd_data(zb_rd_data),
    .zb_wr_req(zb_wr_req), .zb_wr_addr(zb_wr_addr), .zb_wr_data(zb_wr_data),
    .zb_wr_gnt(zb_wr_gnt), .busy(busy), .pass_count(pass_count), .fail_count(fail_count)
  );

  always @(posedge clk) begin
    if (zb_rd_req) rd_cycles++;
    if (zb_rd_req && zb_rd_gnt) rd_hs++;
    if (zb_wr_req) wr_cycles++;
    if (zb_wr_req && zb_wr_gnt) wr_hs++;
    if (frag_out_valid && frag_out_ready) out_hs++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    rd0 = rd_cycles; rdh0 = rd_hs; wr0 = wr_cycles; wrh0 = wr_hs; out0 = out_hs;
  endtask

  function automatic fragment_t mk(input logic [15:0] x, input logic [15:0] y, input logic [31:0] z);
    fragment_t r;
    r.x = x; r.y = y; r.z = z;
    r.u = 32'h0001_2345; r.v = 32'h0006_789A;
    r.r = 8'h11; r.g = 8'h22; r.b = 8'h33; r.valid = 1'b1;
    return r;
  endfunction

  task automatic accept(input fragment_t fr, input logic te, input logic we, input logic [2:0] fn);
    frag_in = fr; test_en = te; write_en = we; depth_func = fn; frag_in_valid = 1'b1;
    check("in_ready_before_accept", frag_in_ready, 1'b1);
    tick();
    frag_in_valid = 1'b0;
    test_en = 1'b0; write_en = 1'b0; depth_func = 3'd0;
  endtask

  task automatic read_phase(input int gnt_wait, input int data_wait, input logic [18:0] addr,
                            input logic [15:0] data);
    for (int i = 0; i < gnt_wait; i++) begin
      check("rd_req_held", zb_rd_req, 1'b1);
      check("rd_addr_stable", zb_rd_addr, addr);
      tick();
    end
    check("rd_req", zb_rd_req, 1'b1);
    check("rd_addr", zb_rd_addr, addr);
    check("busy_rd", busy, 1'b1);
    zb_rd_gnt = 1'b1;
    tick();
    zb_rd_gnt = 1'b0;
    for (int i = 0; i < data_wait; i++) begin
      check("rd_req_dropped", zb_rd_req, 1'b0);
      tick();
    end
    zb_rd_valid = 1'b1; zb_rd_data = data;
    tick();
    zb_rd_valid = 1'b0; zb_rd_data = 16'h0;
  endtask

  task automatic write_phase(input int gnt_wait, input logic [18:0] addr, input logic [15:0] data);
    for (int i = 0; i <= gnt_wait; i++) begin
      check("wr_req", zb_wr_req, 1'b1);
      check("wr_addr", zb_wr_addr, addr);
      check("wr_data", zb_wr_data, data);
      check("out_not_before_write", frag_out_valid, 1'b0);
      if (i == gnt_wait) zb_wr_gnt = 1'b1;
      tick();
    end
    zb_wr_gnt = 1'b0;
  endtask

  task automatic out_phase(input int ready_wait, input fragment_t exp);
    for (int i = 0; i <= ready_wait; i++) begin
      check("out_valid", frag_out_valid, 1'b1);
      check("frag_out", frag_out, exp);
      check("in_ready_low", frag_in_ready, 1'b0);
      if (i == ready_wait) frag_out_ready = 1'b1;
      tick();
    end
    frag_out_ready = 1'b0;
    check("out_valid_cleared", frag_out_valid, 1'b0);
    check("in_ready_after_out", frag_in_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; test_en = 1'b0; write_en = 1'b0; depth_func = 3'd0;
    frag_in = '0; frag_in_valid = 1'b0; frag_out_ready = 1'b0;
    zb_rd_gnt = 1'b0; zb_rd_valid = 1'b0; zb_rd_data = 16'h0; zb_wr_gnt = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", frag_in_ready, 1'b1);
    check("rst_out_valid", frag_out_valid, 1'b0);
    check("rst_rd_req", zb_rd_req, 1'b0);
    check("rst_wr_req", zb_wr_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pass", pass_count, 32'd0);
    check("rst_fail", fail_count, 32'd0);
    check("rst_frag_out", frag_out, '0);
    check("rst_rd_addr", zb_rd_addr, 19'd0);
    check("rst_wr_data", zb_wr_data, 16'd0);

    // LESS pass with write at (3,2): 2*640+3 = 1283
    f = mk(16'd3, 16'd2, 32'h0000_8000);
    accept(f, 1'b1, 1'b1, 3'd1);
    check("t1_in_ready_busy", frag_in_ready, 1'b0);
    read_phase(0, 0, 19'd1283, 16'hFFFF);
    check("t1_cmp_busy", busy, 1'b1);
    tick();
    write_phase(0, 19'd1283, 16'h8000);
    out_phase(0, f);
    check("t1_pass", pass_count, 32'd1);
    check("t1_fail", fail_count, 32'd0);

    // Same pixel, equal depth under LESS: discarded
    snap();
    accept(f, 1'b1, 1'b1, 3'd1);
    read_phase(0, 0, 19'd1283, 16'h8000);
    tick();
    check("t2_in_ready", frag_in_ready, 1'b1);
    check("t2_fail", fail_count, 32'd1);
    check("t2_pass", pass_count, 32'd1);
    check("t2_no_write", wr_cycles - wr0, 0);
    check("t2_no_out", out_hs - out0, 0);

    // Test disabled, negative z: forwarded untouched one cycle after accept
    snap();
    f = mk(16'd10, 16'd20, 32'hFFFF_0000);
    accept(f, 1'b0, 1'b1, 3'd1);
    out_phase(0, f);
    check("t3_no_read", rd_cycles - rd0, 0);
    check("t3_no_write", wr_cycles - wr0, 0);
    check("t3_pass", pass_count, 32'd2);

    // Off-screen x
    snap();
    accept(mk(16'd640, 16'd0, 32'h0000_1000), 1'b1, 1'b1, 3'd7);
    check("t4_in_ready", frag_in_ready, 1'b1);
    check("t4_busy", busy, 1'b0);
    check("t4_fail", fail_count, 32'd2);
    tick();
    check("t4_no_read", rd_cycles - rd0, 0);
    check("t4_no_write", wr_cycles - wr0, 0);

    // LEQUAL equal depth with stalls everywhere at (5,1): addr 645
    snap();
    f = mk(16'd5, 16'd1, 32'h0000_4000);
    accept(f, 1'b1, 1'b1, 3'd3);
    read_phase(3, 5, 19'd645, 16'h4000);
    tick();
    write_phase(0, 19'd645, 16'h4000);
    out_phase(4, f);
    check("t5_one_read", rd_hs - rdh0, 1);
    check("t5_one_write", wr_hs - wrh0, 1);
    check("t5_one_out", out_hs - out0, 1);
    check("t5_pass", pass_count, 32'd3);

    // Reset during RD_WAIT, stale read data afterwards
    accept(mk(16'd1, 16'd1, 32'h0000_1000), 1'b1, 1'b1, 3'd4);
    zb_rd_gnt = 1'b1;
    tick();
    zb_rd_gnt = 1'b0;
    check("t6_in_rd_wait", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    snap();
    zb_rd_valid = 1'b1; zb_rd_data = 16'h0000;
    tick();
    zb_rd_valid = 1'b0;
    check("t6_busy", busy, 1'b0);
    check("t6_in_ready", frag_in_ready, 1'b1);
    check("t6_out_valid", frag_out_valid, 1'b0);
    check("t6_rd_req", zb_rd_req, 1'b0);
    check("t6_rd_addr", zb_rd_addr, 19'd0);
    check("t6_pass", pass_count, 32'd0);
    check("t6_fail", fail_count, 32'd0);
    check("t6_no_write", wr_cycles - wr0, 0);

    // ALWAYS with z=2.0 clamps to all ones at (2,0)
    f = mk(16'd2, 16'd0, 32'h0002_0000);
    accept(f, 1'b1, 1'b1, 3'd7);
    check("t7_no_read", zb_rd_req, 1'b0);
    write_phase(1, 19'd2, 16'hFFFF);
    out_phase(0, f);
    check("t7_pass", pass_count, 32'd1);
    check("t7_reads", rd_cycles - rd0, 0);

    // NEVER discards in place
    accept(mk(16'd4, 16'd4, 32'h0000_0100), 1'b1, 1'b1, 3'd0);
    check("t8_in_ready", frag_in_ready, 1'b1);
    check("t8_fail", fail_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
